// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the tilemap VRAM arbiter
package vram_arb_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE, HOLD} cpu_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;
endpackage

// File: rtl/vram_arb_tagpipe.sv
// vram_arb_tagpipe: 2-stage owner tag pipeline steering RAM read data to video or CPU
// Ports: clk, rst (async, active-high); issue_tag = owner of this cycle's RAM access;
// ram_rdata = synchronous RAM read data; vid_valid/vid_data = video result (issue+2);
// cpu_rdata = CPU read data, held until the next CPU read returns.
import vram_arb_pkg::*;
module vram_arb_tagpipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  tag_t              issue_tag,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic [DATA_W-1:0] cpu_rdata
);
    tag_t tag_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q     <= TAG_NONE;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            tag_q     <= issue_tag;
            vid_valid <= tag_q == TAG_VID;
            if (tag_q == TAG_VID) vid_data <= ram_rdata;
            if (tag_q == TAG_CPU) cpu_rdata <= ram_rdata;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port tilemap RAM arbiter, fixed-latency video fetches over CPU accesses
// Ports: clk, rst (async, active-high); vblank, vid_req/vid_addr -> vid_valid/vid_data (latency 3);
// cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ready/cpu_rdata; ram_addr/ram_we/ram_wdata/ram_rdata
// to the synchronous RAM; stall_cnt = CPU stall cycles.
// Macro VRAM_ARB_STALL_CNT_EN enables the saturating stall counter; otherwise stall_cnt is 0.
import vram_arb_pkg::*;
module vram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stall_cnt
);
    cpu_state_t        state, state_n;
    tag_t              issue_tag;
    logic              vid_issue, cpu_issue;
    logic [ADDR_W-1:0] vid_addr_q, addr_last;
    logic [DATA_W-1:0] wdata_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vid_issue  <= 1'b0;
            vid_addr_q <= '0;
            addr_last  <= '0;
            wdata_last <= '0;
        end else begin
            state      <= state_n;
            vid_issue  <= vid_req && !vblank;
            if (vid_req && !vblank) vid_addr_q <= vid_addr;
            addr_last  <= ram_addr;
            wdata_last <= ram_wdata;
        end
    end
    // Video always owns the port in its issue cycle; the CPU only issues from IDLE
    // into a free slot. rst gates the combinational issue so outputs read 0 in reset.
    always_comb begin
        cpu_issue = !rst && state == IDLE && cpu_req && !vid_issue;
        ram_addr  = vid_issue ? vid_addr_q : cpu_issue ? cpu_addr : addr_last;
        ram_we    = cpu_issue && cpu_we;
        ram_wdata = ram_we ? cpu_wdata : wdata_last;
        issue_tag = vid_issue ? TAG_VID : (cpu_issue && !cpu_we) ? TAG_CPU : TAG_NONE;
        cpu_ready = state == DONE;
        state_n   = state == IDLE    ? (cpu_issue ? (cpu_we ? DONE : RD_WAIT) : IDLE) :
                    state == RD_WAIT ? DONE :
                    state == DONE    ? HOLD : IDLE;
    end
    vram_arb_tagpipe #(.DATA_W(DATA_W)) u_tagpipe (
        .clk       (clk),
        .rst       (rst),
        .issue_tag (issue_tag),
        .ram_rdata (ram_rdata),
        .vid_valid (vid_valid),
        .vid_data  (vid_data),
        .cpu_rdata (cpu_rdata)
    );
`ifdef VRAM_ARB_STALL_CNT_EN
    logic stall;
    assign stall = state == IDLE && cpu_req && vid_issue;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (stall && stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural synchronous RAM
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;
`ifdef VRAM_ARB_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd4;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif
    logic clk = 0, rst = 1, vblank = 0, vid_req = 0, cpu_req = 0, cpu_we = 0;
    logic [AW-1:0] vid_addr = '0, cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] vid_data, cpu_rdata, ram_wdata, ram_rdata;
    logic vid_valid, cpu_ready, ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0] stall_cnt;
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    int cyc = 0, vectors = 0, errors = 0;
    typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
    exp_t vq[$];

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        exp_t e;
        if (vid_valid) begin
            vectors++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL vid_unexpected: vid_valid=1 data=%h at cycle %0d, none expected", vid_data, cyc);
            end else begin
                e = vq.pop_front();
                if (vid_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL vid_fetch: got %h at cycle %0d, expected %h at cycle %0d", vid_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic vid_push(input logic [AW-1:0] a);
        vid_req = 1;
        vid_addr = a;
        vq.push_back('{data: ref_mem[a], cyc: cyc + 3});
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              output logic [DW-1:0] rd, output int lat);
        int start;
        tick;
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        start = cyc; lat = -1; rd = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                lat = cyc - start;
                rd = cpu_rdata;
                break;
            end
        end
        tick;
        cpu_req = 0; cpu_we = 0;
        if (we) ref_mem[a] = wd;
    endtask

    task automatic test_reset;
        tick; tick;
        @(negedge clk);
        vectors++;
        if ({vid_data, vid_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vd=%h vv=%b crd=%h crdy=%b ra=%h we=%b wd=%h sc=%h, required all 0",
                     vid_data, vid_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata, stall_cnt);
        end
        tick;
        rst = 0;
    endtask

    task automatic test_preload;
        logic [DW-1:0] rd;
        int lat;
        for (int i = 0; i < 16; i++) begin
            cpu_access(1, AW'(12'h100 + i), DW'(i * 13 + 7), rd, lat);
            vectors++;
            if (lat != 1) begin
                errors++;
                $display("FAIL preload_write_latency: addr %h latency %0d, required 1", 12'h100 + i, lat);
            end
        end
    endtask

    task automatic test_vid_fetch;
        logic [DW-1:0] rd;
        int lat;
        cpu_access(1, 11'h123, 8'h5A, rd, lat);
        tick;
        vid_push(11'h123);
        tick;
        vid_req = 0;
        @(negedge clk);
        vectors++;
        if (ram_addr !== 11'h123 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL vid_issue_addr: ram_addr=%h ram_we=%b, required 123 / 0", ram_addr, ram_we);
        end
        repeat (3) tick;
        @(negedge clk);
        vectors++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL vid_fetch_missing: %0d results outstanding, required 0", vq.size());
        end
    endtask

    task automatic test_cpu_write_read;
        logic [DW-1:0] rd;
        int lat;
        tick;
        cpu_req = 1; cpu_we = 1; cpu_addr = 11'h010; cpu_wdata = 8'hA5;
        @(negedge clk);
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h010 || ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_write_issue: we=%b addr=%h wdata=%h, required 1 / 010 / a5", ram_we, ram_addr, ram_wdata);
        end
        tick;
        @(negedge clk);
        vectors++;
        if (cpu_ready !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_write_ready: cpu_ready=%b ram_we=%b, required 1 / 0", cpu_ready, ram_we);
        end
        tick;
        cpu_req = 0; cpu_we = 0;
        ref_mem[11'h010] = 8'hA5;
        cpu_access(0, 11'h010, '0, rd, lat);
        vectors++;
        if (rd !== 8'hA5 || lat != 2) begin
            errors++;
            $display("FAIL cpu_readback: data %h latency %0d, required a5 latency 2", rd, lat);
        end
    endtask

    task automatic test_no_swap;
        logic [DW-1:0] rd;
        int lat;
        cpu_access(1, 11'h200, 8'h11, rd, lat);
        cpu_access(1, 11'h300, 8'h22, rd, lat);
        tick;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h200;
        vid_push(11'h300);
        tick;
        vid_push(11'h101);
        tick;
        vid_req = 0;
        @(negedge clk);
        vectors++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 8'h11) begin
            errors++;
            $display("FAIL no_swap_cpu: cpu_ready=%b cpu_rdata=%h, required 1 / 11", cpu_ready, cpu_rdata);
        end
        tick;
        cpu_req = 0;
        repeat (3) tick;
        @(negedge clk);
        vectors++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL no_swap_vid_missing: %0d results outstanding, required 0", vq.size());
        end
    endtask

    task automatic test_stall;
        int t, rdy;
        logic [DW-1:0] rd;
        tick; tick;
        t = cyc; rdy = -1; rd = 'x;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) vid_push(AW'(12'h104 + i));
            else vid_req = 0;
            if (i == 1) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 11'h10A;
            end
            @(negedge clk);
            if (i == 5) begin
                vectors++;
                if (ram_addr !== 11'h10A) begin
                    errors++;
                    $display("FAIL stall_cpu_issue: ram_addr=%h in 5th request cycle, required 10a", ram_addr);
                end
            end
            if (cpu_ready) begin
                rdy = cyc;
                rd = cpu_rdata;
                break;
            end
            tick;
        end
        tick;
        cpu_req = 0;
        vectors++;
        if (rdy != t + 7 || rd !== ref_mem[11'h10A]) begin
            errors++;
            $display("FAIL stall_cpu_ready: ready at cycle %0d data %h, required cycle %0d data %h", rdy, rd, t + 7, ref_mem[11'h10A]);
        end
        @(negedge clk);
        vectors++;
        if (stall_cnt !== EXP_STALL) begin
            errors++;
            $display("FAIL stall_cnt: %0d, required %0d", stall_cnt, EXP_STALL);
        end
        repeat (3) tick;
    endtask

    task automatic test_back_to_back;
        tick;
        for (int i = 0; i < 8; i++) begin
            vid_push(AW'(12'h100 + $urandom_range(0, 15)));
            tick;
        end
        vid_req = 0;
        repeat (4) tick;
        @(negedge clk);
        vectors++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_missing: %0d results outstanding, required 0", vq.size());
        end
    endtask

    task automatic test_vblank;
        tick;
        vid_push(11'h105);
        tick;
        vid_req = 0;
        repeat (4) tick;
        vblank = 1;
        vid_req = 1;
        vid_addr = 11'h333;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ram_addr !== 11'h105 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL vblank_drop: ram_addr=%h ram_we=%b, required 105 / 0", ram_addr, ram_we);
            end
            tick;
            vid_req = 0;
        end
        vblank = 0;
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] rd;
        int lat;
        tick;
        cpu_req = 1; cpu_we = 0; cpu_addr = 11'h100;
        vid_req = 1; vid_addr = 11'h101;
        tick;
        vid_req = 0;
        cpu_req = 0;
        rst = 1;
        #1;
        vectors++;
        if ({vid_data, vid_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: vd=%h vv=%b crd=%h crdy=%b ra=%h we=%b wd=%h sc=%h, required all 0",
                     vid_data, vid_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata, stall_cnt);
        end
        tick; tick;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (cpu_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_ready: cpu_ready=%b after reset, required 0", cpu_ready);
            end
            tick;
        end
        cpu_access(0, 11'h100, '0, rd, lat);
        vectors++;
        if (rd !== ref_mem[11'h100] || lat != 2) begin
            errors++;
            $display("FAIL reset_mid_recover: data %h latency %0d, required %h latency 2", rd, lat, ref_mem[11'h100]);
        end
    endtask

    initial begin
        test_reset;
        test_preload;
        test_vid_fetch;
        test_cpu_write_read;
        test_no_swap;
        test_stall;
        test_back_to_back;
        test_vblank;
        test_reset_mid;
        repeat (4) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, width of every tilemap RAM address.
REQ-002 Parameter DATA_W, default 8, width of every tilemap RAM data bus.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 vblank  input  1  vertical blanking; video fetches ignored while high.
REQ-006 vid_req  input  1  one-cycle strobe, video tile fetch request.
REQ-007 vid_addr  input  ADDR_W  video fetch address, sampled with vid_req.
REQ-008 vid_data  output  DATA_W  fetched tile code.
REQ-009 vid_valid  output  1  one-cycle strobe, vid_data valid.
REQ-010 cpu_req  input  1  CPU access request, level, held until cpu_ready.
REQ-011 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req.
REQ-012 cpu_addr  input  ADDR_W  CPU address; stable while cpu_req.
REQ-013 cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req.
REQ-014 cpu_rdata  output  DATA_W  CPU read data, valid with cpu_ready on reads.
REQ-015 cpu_ready  output  1  one-cycle strobe, CPU access complete.
REQ-016 ram_addr  output  ADDR_W  RAM address; ram_we  output  1; ram_wdata  output  DATA_W.
REQ-017 ram_rdata  input  DATA_W  RAM read data, synchronous, one cycle after address.
REQ-018 stall_cnt  output  16  CPU stall-cycle count (see Configuration).

Function
REQ-019 RAM is single-ported; at most one access is issued per cycle.
REQ-020 An accepted vid_req in cycle t is issued to RAM in cycle t+1, unconditionally.
REQ-021 vid_valid is high and vid_data holds the RAM word during cycle t+3; fixed latency 3, no exceptions.
REQ-022 vid_req in consecutive cycles is accepted every cycle, fully pipelined.
REQ-023 vid_req while vblank=1 is dropped; no RAM access and no vid_valid result.
REQ-024 CPU states: IDLE, RD_WAIT, DONE, HOLD.
REQ-025 IDLE: cpu_req=1 with no video issue due in this cycle -> issue the CPU access; read -> RD_WAIT; write (ram_we=1 for that one cycle) -> DONE.
REQ-026 IDLE: cpu_req=1 with a video issue due -> remain in IDLE and do not issue the CPU access (stall cycle).
REQ-027 RD_WAIT -> DONE after one cycle; video issues are allowed during RD_WAIT.
REQ-028 DONE: cpu_ready=1 for exactly this cycle -> HOLD.
REQ-029 DONE, reads: cpu_rdata holds the CPU's word.
REQ-030 A 2-stage owner tag pipeline (video/CPU/none) steers ram_rdata to the correct requester; data is never swapped.
REQ-031 HOLD: cpu_req ignored for one cycle -> IDLE; prevents re-serving a held request.
REQ-032 CPU write latency is issue+1, and CPU read latency is issue+2, to cpu_ready.
REQ-033 ram_we=0 in every cycle except CPU write issue.
REQ-034 ram_addr and ram_wdata are don't-care when idle and are held at the last value.

Reset
REQ-035 rst=1: state IDLE, tag pipeline cleared, and all outputs 0 (vid_data, vid_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata, stall_cnt).
REQ-036 Reset mid-access discards in-flight results; no vid_valid or cpu_ready results from pre-reset requests.

Configuration
REQ-037 Macro VRAM_ARB_STALL_CNT_EN defined: stall_cnt increments on each REQ-026 stall cycle, saturates at 16'hFFFF, and clears only on rst.
REQ-038 Macro VRAM_ARB_STALL_CNT_EN undefined: the stall_cnt port is present, tied to 0, and the counter logic is absent.

Structure
REQ-039 Shared package vram_arb_pkg holds the CPU state enum, the owner-tag enum (TAG_NONE, TAG_VID, TAG_CPU) and the stall_cnt saturation constant.
REQ-040 Sub-module vram_arb_tagpipe (2-stage tag/return steering) is used; everything else stays in vram_arbiter.

Verification
REQ-041 Reset, then vid_req at t with vid_addr=0x123, RAM[0x123]=0x5A -> ram_addr=0x123 at t+1, and vid_valid=1 with vid_data=0x5A at t+3.
REQ-042 CPU write 0xA5 to 0x010 with video idle -> ram_we=1 for one cycle at issue, cpu_ready at issue+1, and a subsequent read returns 0xA5 at issue+2.
REQ-043 CPU read issued, vid_req in the RD_WAIT cycle, RAM[cpu]=0x11 and RAM[vid]=0x22 -> cpu_rdata=0x11 and vid_data=0x22, with no swap.
REQ-044 vid_req on 4 consecutive cycles with cpu_req held -> 4 stall cycles, the CPU issues on the 5th, and stall_cnt=4 (macro defined) or 0 (macro undefined).
REQ-045 rst asserted in RD_WAIT -> no cpu_ready or vid_valid afterwards and all outputs 0; vid_req with vblank=1 -> no RAM access.
